// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and constants for the CNN layer blocks and the layer load
// responder: word/address widths, buffer depth, the signed data word type,
// the RAM address type and the load responder state encoding.
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_SZ   = 16;
    localparam int ADDR_SZ   = 16;
    localparam int MAX_WORDS = 1024;

    typedef logic signed [DATA_SZ-1:0] word_t;
    typedef logic        [ADDR_SZ-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/image_load_responder_mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// LAT-stage shift register that carries {valid, idx} of each RAM read so the
// returning data can be written to the right buffer slot. flush clears every
// valid bit on the next edge (used when a transfer is abandoned).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           drop everything in flight
//   in_valid/in_idx read issued this cycle and its buffer index
//   out_valid/out_idx  read whose data is on mem_rdata this cycle
//   in_flight       a read is still in stages ahead of the output stage
// -----------------------------------------------------------------------------
module mem_rd_pipe #(
    parameter int LAT   = 1,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             in_flight
);
    import cnn_pkg::*;

    logic [LAT-1:0]   valid_q;
    logic [LAT-1:0]   valid_d;
    logic [IDX_W-1:0] idx_q [LAT];
    logic [IDX_W-1:0] idx_d [LAT];

    // Next-state of the shift register; flush only needs to kill the valids.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            valid_d[0] = in_valid;
            for (int i = 1; i < LAT; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
        idx_d[0] = in_idx;
        for (int i = 1; i < LAT; i++) begin
            idx_d[i] = idx_q[i-1];
        end
    end

    // The output stage is consumed on the coming edge, so it does not count
    // as still in flight.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            in_flight = in_flight | valid_q[i];
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/image_load_responder.sv
// -----------------------------------------------------------------------------
// image_load_responder
// Responder side of the layer load interface. On a request it reads
// load_size*load_size words (clamped to MAX_WORDS) from the data RAM starting
// at load_addr, one per cycle, into an internal buffer exposed as load_out,
// then raises load_done until the initiator drops load_enable.
//
// Build option: define LOAD_ZERO_FILL_EN to zero every buffer entry beyond
// the transfer length when a request is accepted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   load_enable                request level, held until load_done is seen
//   load_addr, load_size       start address and image side length
//   load_done, load_err        transfer complete / request was clamped
//   load_out                   buffer contents, row-major from load_addr
//   busy                       not idle
//   mem_rd_en, mem_addr        RAM read strobe and address
//   mem_rdata                  RAM data, MEM_LAT cycles after the strobe
// -----------------------------------------------------------------------------
module image_load_responder #(
    parameter int DATA_SZ   = cnn_pkg::DATA_SZ,
    parameter int ADDR_SZ   = cnn_pkg::ADDR_SZ,
    parameter int MAX_WORDS = cnn_pkg::MAX_WORDS,
    parameter int MEM_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_enable,
    input  logic [ADDR_SZ-1:0]        load_addr,
    input  logic [DATA_SZ-1:0]        load_size,
    output logic                      load_done,
    output logic                      load_err,
    output logic signed [DATA_SZ-1:0] load_out [0:MAX_WORDS-1],
    output logic                      busy,
    output logic                      mem_rd_en,
    output logic [ADDR_SZ-1:0]        mem_addr,
    input  logic [DATA_SZ-1:0]        mem_rdata
);
    import cnn_pkg::*;

    localparam int IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CNT_W  = IDX_W + 1;
    localparam int PROD_W = 2 * DATA_SZ;

    load_state_t          state_q, state_d;
    logic [ADDR_SZ-1:0]   base_q, base_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 load_done_q, load_done_d;
    logic                 load_err_q, load_err_d;
    logic                 busy_q, busy_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_SZ-1:0]   mem_addr_q, mem_addr_d;

    logic [PROD_W-1:0]    prod_s;
    logic [CNT_W-1:0]     req_cnt_s;
    logic                 req_err_s;
    logic [CNT_W-1:0]     idx_nxt_s;
    logic                 accept_s;
    logic                 abort_s;
    logic                 cap_valid_s;
    logic [IDX_W-1:0]     cap_idx_s;
    logic                 in_flight_s;
    logic                 cap_we_s;

    logic signed [DATA_SZ-1:0] buf_q [0:MAX_WORDS-1];

    // Requested word count, widened so the square cannot overflow, then clamped.
    always_comb begin
        prod_s = {{DATA_SZ{1'b0}}, load_size} * {{DATA_SZ{1'b0}}, load_size};
        if (prod_s > PROD_W'(MAX_WORDS)) begin
            req_cnt_s = CNT_W'(MAX_WORDS);
            req_err_s = 1'b1;
        end else begin
            req_cnt_s = prod_s[CNT_W-1:0];
            req_err_s = 1'b0;
        end
    end

    assign idx_nxt_s = {1'b0, idx_q} + CNT_W'(1);

    // Transfer FSM. Outputs are computed one edge ahead so they come from flops.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        idx_d       = idx_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_addr_d  = mem_addr_q;
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_enable) begin
                    accept_s = 1'b1;
                    base_d   = load_addr;
                    cnt_d    = req_cnt_s;
                    err_d    = req_err_s;
                    idx_d    = '0;
                    if (req_cnt_s == '0) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        load_err_d  = req_err_s;
                    end else begin
                        state_d     = READ;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = load_addr;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (!load_enable) begin
                    abort_s     = 1'b1;
                    state_d     = IDLE;
                    mem_rd_en_d = 1'b0;
                end else if (idx_nxt_s < cnt_q) begin
                    idx_d      = idx_nxt_s[IDX_W-1:0];
                    mem_addr_d = base_q + ADDR_SZ'(idx_nxt_s);
                end else begin
                    // Read for idx_q is the last one; it enters the pipe this edge.
                    state_d     = DRAIN;
                    mem_rd_en_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!load_enable) begin
                    abort_s = 1'b1;
                    state_d = IDLE;
                end else if (!in_flight_s) begin
                    // The final capture (if any) happens on this same edge.
                    state_d     = DONE;
                    load_done_d = 1'b1;
                    load_err_d  = err_q;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (!load_enable) begin
                    state_d     = IDLE;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                load_done_d = 1'b0;
                load_err_d  = 1'b0;
                mem_rd_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    mem_rd_pipe #(
        .LAT   (MEM_LAT),
        .IDX_W (IDX_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_s),
        .in_valid  (mem_rd_en_q),
        .in_idx    (idx_q),
        .out_valid (cap_valid_s),
        .out_idx   (cap_idx_s),
        .in_flight (in_flight_s)
    );

    // Reset and an abort on the same edge both suppress the capture.
    assign cap_we_s = cap_valid_s & ~abort_s & ~reset;

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            busy_q      <= busy_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Buffer storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (cap_we_s) begin
            buf_q[cap_idx_s] <= $signed(mem_rdata);
        end
`ifdef LOAD_ZERO_FILL_EN
        if (accept_s && !reset) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
                if (CNT_W'(i) >= req_cnt_s) begin
                    buf_q[i] <= '0;
                end
            end
        end
`endif
    end

    assign load_out  = buf_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign busy      = busy_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_image_load_responder.sv
// -----------------------------------------------------------------------------
// tb_image_load_responder
// Two responders share one clock: dut1 with a 1-cycle RAM, dut3 with a
// 3-cycle RAM. The RAM returns ram_val(a) = a + ram_ofs; outside a read it
// returns 16'hDEAD so a stray capture shows up in the buffer.
// -----------------------------------------------------------------------------
module tb_image_load_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ram_ofs = 16'h0100;

    function automatic logic [15:0] ram_val(input logic [15:0] a);
        return a + ram_ofs;
    endfunction

    // Reference model: words moved and clamp flag for a side length.
    function automatic int exp_cnt(input logic [15:0] s);
        int p;
        p = int'(s) * int'(s);
        return (p > 1024) ? 1024 : p;
    endfunction

    function automatic logic exp_err(input logic [15:0] s);
        return (int'(s) * int'(s)) > 1024;
    endfunction

    // ---------------- dut1 (MEM_LAT = 1) ----------------
    logic               reset1 = 1'b1, en1 = 1'b0, done1, err1, busy1, rden1;
    logic [15:0]        addr1 = 16'h0, size1 = 16'h0, maddr1, rdata1;
    logic signed [15:0] out1 [0:1023];

    image_load_responder #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset1), .load_enable(en1), .load_addr(addr1),
        .load_size(size1), .load_done(done1), .load_err(err1), .load_out(out1),
        .busy(busy1), .mem_rd_en(rden1), .mem_addr(maddr1), .mem_rdata(rdata1)
    );

    // ---------------- dut3 (MEM_LAT = 3) ----------------
    logic               reset3 = 1'b1, en3 = 1'b0, done3, err3, busy3, rden3;
    logic [15:0]        addr3 = 16'h0, size3 = 16'h0, maddr3, rdata3;
    logic signed [15:0] out3 [0:1023];

    image_load_responder #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset3), .load_enable(en3), .load_addr(addr3),
        .load_size(size3), .load_done(done3), .load_err(err3), .load_out(out3),
        .busy(busy3), .mem_rd_en(rden3), .mem_addr(maddr3), .mem_rdata(rdata3)
    );

    // RAM models with the matching read latency.
    logic        v3a = 1'b0, v3b = 1'b0;
    logic [15:0] a3a = 16'h0, a3b = 16'h0;
    always @(posedge clk) begin
        rdata1 <= (rden1 === 1'b1) ? ram_val(maddr1) : 16'hDEAD;
        v3a    <= (rden3 === 1'b1);
        a3a    <= maddr3;
        v3b    <= v3a;
        a3b    <= a3a;
        rdata3 <= v3b ? ram_val(a3b) : 16'hDEAD;
    end

    // Read logs: every address strobed.
    logic [15:0] rdq1 [$];
    logic [15:0] rdq3 [$];
    always @(posedge clk) begin
        if (rden1 === 1'b1) rdq1.push_back(maddr1);
        if (rden3 === 1'b1) rdq3.push_back(maddr3);
    end

    // Raise a request and wait for load_done; done_cyc is the first cycle
    // (counting the cycle after the accepting edge as 1) with load_done high,
    // or -1 on timeout. Address/size are scrambled after acceptance.
    task automatic start_load(input int which, input logic [15:0] a,
                              input logic [15:0] s, output int done_cyc);
        @(negedge clk);
        if (which == 1) begin rdq1.delete(); en1 = 1'b1; addr1 = a; size1 = s; end
        else            begin rdq3.delete(); en3 = 1'b1; addr3 = a; size3 = s; end
        done_cyc = -1;
        for (int c = 1; c <= 1200; c++) begin
            @(negedge clk);
            if (((which == 1) ? done1 : done3) === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (c == 1) begin
                if (which == 1) begin addr1 = 16'($urandom); size1 = 16'($urandom); end
                else            begin addr3 = 16'($urandom); size3 = 16'($urandom); end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 10;
        if (done1 !== 1'b0)  begin n_fail++; $display("FAIL reset_done1 got %b want 0", done1); end
        if (err1 !== 1'b0)   begin n_fail++; $display("FAIL reset_err1 got %b want 0", err1); end
        if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        if (rden1 !== 1'b0)  begin n_fail++; $display("FAIL reset_rden1 got %b want 0", rden1); end
        if (maddr1 !== 16'h0) begin n_fail++; $display("FAIL reset_addr1 got %h want 0", maddr1); end
        if (done3 !== 1'b0)  begin n_fail++; $display("FAIL reset_done3 got %b want 0", done3); end
        if (err3 !== 1'b0)   begin n_fail++; $display("FAIL reset_err3 got %b want 0", err3); end
        if (busy3 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy3 got %b want 0", busy3); end
        if (rden3 !== 1'b0)  begin n_fail++; $display("FAIL reset_rden3 got %b want 0", rden3); end
        if (maddr3 !== 16'h0) begin n_fail++; $display("FAIL reset_addr3 got %h want 0", maddr3); end
        reset1 = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);
    endtask

    // Full transfer on dut1 checked against the model, then release.
    task automatic test_transfer(input string nm, input logic [15:0] a, input logic [15:0] s);
        int dc, cnt, bad_a, bad_d;
        logic [15:0] e;
        cnt = exp_cnt(s);
        start_load(1, a, s, dc);
        n_checks += 6;
        if (dc != ((cnt == 0) ? 1 : cnt + 2))
            begin n_fail++; $display("FAIL %s_done_cycle got %0d want %0d", nm, dc, (cnt == 0) ? 1 : cnt + 2); end
        if (rdq1.size() != cnt)
            begin n_fail++; $display("FAIL %s_read_count got %0d want %0d", nm, rdq1.size(), cnt); end
        bad_a = 0;
        bad_d = 0;
        for (int i = 0; i < cnt && i < rdq1.size(); i++) begin
            e = a + 16'(i);
            if (rdq1[i] !== e) begin
                if (bad_a == 0) $display("FAIL %s_addr[%0d] got %h want %h", nm, i, rdq1[i], e);
                bad_a++;
            end
            if (out1[i] !== ram_val(e)) begin
                if (bad_d == 0) $display("FAIL %s_data[%0d] got %h want %h", nm, i, out1[i], ram_val(e));
                bad_d++;
            end
        end
        if (bad_a != 0) n_fail++;
        if (bad_d != 0) n_fail++;
        if (err1 !== exp_err(s)) begin n_fail++; $display("FAIL %s_err got %b want %b", nm, err1, exp_err(s)); end
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL %s_busy_done got %b want 1", nm, busy1); end
        en1 = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL %s_done_clear got %b want 0", nm, done1); end
        if (err1 !== 1'b0)  begin n_fail++; $display("FAIL %s_err_clear got %b want 0", nm, err1); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL %s_busy_clear got %b want 0", nm, busy1); end
    endtask

    task automatic test_basic();
        ram_ofs = 16'h0100;
        test_transfer("basic", 16'h0010, 16'd2);
        n_checks += 1;
        if (out1[3] !== 16'sh0113) begin n_fail++; $display("FAIL basic_word3 got %h want 0113", out1[3]); end
    endtask

    task automatic test_zero_size();
        test_transfer("zero", 16'($urandom), 16'd0);
    endtask

    task automatic test_clamp();
        ram_ofs = 16'($urandom);
        test_transfer("clamp", 16'($urandom), 16'd40);
    endtask

    task automatic test_wrap();
        ram_ofs = 16'h2000;
        test_transfer("wrap", 16'hFFFE, 16'd2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            ram_ofs = 16'($urandom);
            test_transfer("b2b", 16'($urandom), 16'($urandom_range(0, 12)));
        end
    endtask

    task automatic test_abort();
        bit saw_done, saw_rd;
        ram_ofs = 16'h0300;
        @(negedge clk);
        rdq1.delete();
        en1 = 1'b1; addr1 = 16'h0040; size1 = 16'd4;
        repeat (5) @(negedge clk);
        en1 = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (rden1 !== 1'b0) begin n_fail++; $display("FAIL abort_rden got %b want 0", rden1); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy1); end
        saw_done = 1'b0;
        saw_rd   = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done1 !== 1'b0) saw_done = 1'b1;
            if (rden1 !== 1'b0) saw_rd = 1'b1;
        end
        n_checks += 3;
        if (saw_done) begin n_fail++; $display("FAIL abort_no_done got 1 want 0"); end
        if (saw_rd)   begin n_fail++; $display("FAIL abort_no_read got 1 want 0"); end
        if (rdq1.size() != 5) begin n_fail++; $display("FAIL abort_read_count got %0d want 5", rdq1.size()); end
        ram_ofs = 16'h0700;
        test_transfer("after_abort", 16'($urandom), 16'd3);
    endtask

    task automatic test_reset_mid_read();
        int dc;
        int bad;
        logic [15:0] e;
        ram_ofs = 16'h5000;
        start_load(3, 16'h0200, 16'd4, dc);
        n_checks += 2;
        if (dc != 20) begin n_fail++; $display("FAIL lat3_done_cycle got %0d want 20", dc); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (out3[i] !== 16'h5200 + 16'(i)) bad++;
        if (bad != 0) begin n_fail++; $display("FAIL lat3_data got %0d bad want 0", bad); end
        en3 = 1'b0;
        @(negedge clk);
        ram_ofs = 16'h7000;
        en3 = 1'b1; addr3 = 16'h0200; size3 = 16'd4;
        repeat (5) @(negedge clk);
        reset3 = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (done3 !== 1'b0)  begin n_fail++; $display("FAIL midrst_done got %b want 0", done3); end
        if (err3 !== 1'b0)   begin n_fail++; $display("FAIL midrst_err got %b want 0", err3); end
        if (busy3 !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy3); end
        if (rden3 !== 1'b0)  begin n_fail++; $display("FAIL midrst_rden got %b want 0", rden3); end
        if (maddr3 !== 16'h0) begin n_fail++; $display("FAIL midrst_addr got %h want 0", maddr3); end
        en3 = 1'b0;
        reset3 = 1'b0;
        repeat (8) @(negedge clk);
        // Word 0 landed before reset; the reset edge and later captures must not.
        n_checks += 3;
        if (out3[0] !== 16'h7200) begin n_fail++; $display("FAIL midrst_word0 got %h want 7200", out3[0]); end
        bad = 0;
        for (int i = 1; i < 16; i++) if (out3[i] !== 16'h5200 + 16'(i)) bad++;
        if (bad != 0) begin n_fail++; $display("FAIL midrst_stale_capture got %0d bad want 0", bad); end
        if (busy3 !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b want 0", busy3); end

        // Small load after a larger one: tail is zero-filled or left stale.
        ram_ofs = 16'h1234;
        start_load(3, 16'h0300, 16'd4, dc);
        en3 = 1'b0;
        @(negedge clk);
        ram_ofs = 16'h4321;
        start_load(3, 16'h0400, 16'd2, dc);
        n_checks += 3;
        if (dc != 8) begin n_fail++; $display("FAIL fill_done_cycle got %0d want 8", dc); end
        bad = 0;
        for (int i = 0; i < 4; i++) if (out3[i] !== 16'h4721 + 16'(i)) bad++;
        if (bad != 0) begin n_fail++; $display("FAIL fill_head got %0d bad want 0", bad); end
        bad = 0;
        for (int i = 4; i < 16; i++) begin
`ifdef LOAD_ZERO_FILL_EN
            e = 16'h0000;
`else
            e = 16'h1534 + 16'(i);
`endif
            if (out3[i] !== e) bad++;
        end
        if (bad != 0) begin n_fail++; $display("FAIL fill_tail got %0d bad want 0", bad); end
        en3 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_clamp();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
